// File: rtl/alu_dec_pkg.sv
// Shared types and constants for the ALU result BCD decoder: FSM state
// encoding, default geometry, and active-high {g,f,e,d,c,b,a} segment patterns.
package alu_dec_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEF_RES_W    = 13;
   localparam int DEF_MAG_W    = 8;
   localparam int DEF_SIGN_BIT = 9;
   localparam int DEF_DIGITS   = 4;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b1000000;
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;

endpackage

// File: rtl/alu_res_decode_seg7_digit.sv
// seg7_digit: combinational BCD digit to 7-segment pattern.
// Codes 10-15 cannot occur from the converter; they map to blank.
module seg7_digit
   import alu_dec_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // one pattern per decimal code
   always_comb begin
      seg = SEG_BLANK;
      unique case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/alu_res_decode.sv
// alu_res_decode: sequential double-dabble converter from the ALU result word
// to DIGITS packed BCD digits plus a negative flag. One bit per clock, RES_W
// clocks per conversion; outputs only change on the completing edge.
// Optional: define ALU_DEC_SEG7_EN to add registered 7-segment outputs.
module alu_res_decode
   import alu_dec_pkg::*;
#(
   parameter int RES_W    = DEF_RES_W,
   parameter int MAG_W    = DEF_MAG_W,
   parameter int SIGN_BIT = DEF_SIGN_BIT,
   parameter int DIGITS   = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [RES_W-1:0]      res,
   input  logic                  sign_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [DIGITS*4-1:0]   bcd
`ifdef ALU_DEC_SEG7_EN
   ,
   output logic [DIGITS*7-1:0]   seg,
   output logic [6:0]            seg_sign
`endif
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = $clog2(RES_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RES_W - 1);

   state_t             state;
   logic [RES_W-1:0]   sreg, sreg_nxt, cap;
   logic [BCD_W-1:0]   scratch, adj, scratch_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               sign_l;

   // value to capture: low magnitude zero-extended in signed mode, whole word otherwise
   always_comb begin
      cap = '0;
      if (sign_mode) cap[MAG_W-1:0] = res[MAG_W-1:0];
      else           cap = res;
   end

   // one double-dabble step: +3 on digits >= 5, then shift {scratch, sreg} left
   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++)
         if (scratch[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = scratch[d*4 +: 4] + 4'd3;
      scratch_nxt = (adj << 1) | BCD_W'(sreg[RES_W-1]);
      sreg_nxt    = sreg << 1;
   end

`ifdef ALU_DEC_SEG7_EN
   logic [DIGITS*7-1:0] seg_nxt;

   // encode the final digits so seg lands on the same edge as bcd
   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      seg7_digit u_seg (
         .digit (scratch_nxt[g*4 +: 4]),
         .seg   (seg_nxt[g*7 +: 7])
      );
   end
`endif

   // control FSM; registered status and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sreg     <= '0;
         scratch  <= '0;
         cnt      <= '0;
         sign_l   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         neg      <= 1'b0;
         bcd      <= '0;
`ifdef ALU_DEC_SEG7_EN
         seg      <= '0;
         seg_sign <= SEG_BLANK;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  sreg    <= cap;
                  // a negative zero is reported as positive
                  sign_l  <= sign_mode & res[SIGN_BIT] & (|res[MAG_W-1:0]);
                  scratch <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= scratch_nxt;
               sreg    <= sreg_nxt;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bcd   <= scratch_nxt;
                  neg   <= sign_l;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= IDLE;
`ifdef ALU_DEC_SEG7_EN
                  seg      <= seg_nxt;
                  seg_sign <= sign_l ? SEG_MINUS : SEG_BLANK;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_res_decode.sv
// Directed self-checking bench for alu_res_decode. Seven-segment checks are
// compiled in only when ALU_DEC_SEG7_EN is defined.
module tb_alu_res_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [12:0] res;
   logic        sign_mode;
   logic        busy, done, neg;
   logic [15:0] bcd;
`ifdef ALU_DEC_SEG7_EN
   logic [27:0] seg;
   logic [6:0]  seg_sign;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   alu_res_decode dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .res       (res),
      .sign_mode (sign_mode),
      .busy      (busy),
      .done      (done),
      .neg       (neg),
      .bcd       (bcd)
`ifdef ALU_DEC_SEG7_EN
      ,
      .seg       (seg),
      .seg_sign  (seg_sign)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // drive one start pulse; res is scrambled afterwards to show it is not re-read
   task automatic start_conv(input logic [12:0] r, input logic m);
      res       = r;
      sign_mode = m;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      res       = 13'h1ABC;
      sign_mode = ~m;
   endtask

   // wait (bounded) for done; returns edges waited and busy-high cycles seen
   task automatic wait_done(output int lat, output int bcyc);
      lat  = 0;
      bcyc = busy ? 1 : 0;
      while (!done && lat < 40) begin
         tick();
         lat++;
         if (busy) bcyc++;
      end
   endtask

   task automatic conv(input string tag, input logic [12:0] r, input logic m,
                       input logic [15:0] eb, input logic en);
      int lat, bcyc;
      start_conv(r, m);
      chk({tag, " busy_after_start"}, busy, 1);
      wait_done(lat, bcyc);
      chk({tag, " latency"}, lat, 13);
      chk({tag, " busy_cycles"}, bcyc, 13);
      chk({tag, " bcd"}, bcd, eb);
      chk({tag, " neg"}, neg, en);
`ifdef ALU_DEC_SEG7_EN
      chk({tag, " seg_sign"}, seg_sign, en ? 7'b1000000 : 7'b0000000);
`endif
      tick();
      chk({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      int lat, bcyc, ndone;
      rst_n = 1'b0; start = 1'b0; res = '0; sign_mode = 1'b0;
      #2;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst neg", neg, 0);
      chk("rst bcd", bcd, 0);
`ifdef ALU_DEC_SEG7_EN
      chk("rst seg", seg, 0);
      chk("rst seg_sign", seg_sign, 0);
`endif
      tick();
      rst_n = 1'b1;
      tick();

      conv("s_22B", 13'h22B, 1'b1, 16'h0043, 1'b1);
`ifdef ALU_DEC_SEG7_EN
      chk("s_22B seg", seg, {7'b0111111, 7'b0111111, 7'b1100110, 7'b1001111});
`endif
      conv("u_1FFF", 13'h1FFF, 1'b0, 16'h8191, 1'b0);
      conv("s_negzero", 13'h200, 1'b1, 16'h0000, 1'b0);
`ifdef ALU_DEC_SEG7_EN
      chk("s_negzero seg_sign", seg_sign, 0);
`endif
      conv("u_22B", 13'h22B, 1'b0, 16'h0555, 1'b0);
      conv("s_1CFF", 13'h1CFF, 1'b1, 16'h0255, 1'b0);
      conv("s_2FF", 13'h2FF, 1'b1, 16'h0255, 1'b1);
      conv("u_0", 13'h0, 1'b0, 16'h0000, 1'b0);

      // start while busy is ignored; outputs hold the previous result meanwhile
      start_conv(13'h22B, 1'b1);
      repeat (4) tick();
      res = 13'h005; sign_mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ign hold_bcd", bcd, 16'h0000);
      chk("ign busy", busy, 1);
      wait_done(lat, bcyc);
      chk("ign latency", lat, 8);
      chk("ign bcd", bcd, 16'h0043);
      chk("ign neg", neg, 1);
      // back-to-back: start raised in the done cycle
      start_conv(13'h005, 1'b1);
      chk("b2b busy", busy, 1);
      chk("b2b hold_bcd", bcd, 16'h0043);
      wait_done(lat, bcyc);
      chk("b2b latency", lat, 13);
      chk("b2b bcd", bcd, 16'h0005);
      chk("b2b neg", neg, 0);
      tick();

      // reset mid-conversion aborts with no done pulse
      start_conv(13'h1FFF, 1'b0);
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("arst busy", busy, 0);
      chk("arst done", done, 0);
      chk("arst bcd", bcd, 0);
      chk("arst neg", neg, 0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         tick();
         if (done) ndone++;
      end
      chk("arst no_done", ndone, 0);
      conv("post_rst_u10", 13'd10, 1'b0, 16'h0010, 1'b0);
`ifdef ALU_DEC_SEG7_EN
      chk("u10 seg0", seg[6:0], 7'b0111111);
      chk("u10 seg1", seg[13:7], 7'b0000110);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
